// File: rtl/match_encoder.sv
`default_nettype none
// ============================================================================
// Module   : match_encoder
// Purpose  : Captures an associative-array match vector and serialises every
//            matching index, lowest first, over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module match_encoder #(
    parameter int WIDTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             capture,
    input  logic [WIDTH-1:0] match_vec,
    input  logic             ready_in,
    output logic             valid_out,
    output logic [AW-1:0]    addr_out,
    output logic             last_out,
    output logic [AW:0]      hit_count,
    output logic             hit,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_one      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [AW:0]      c_cnt_one  = {{AW{1'b0}}, 1'b1};

    state_t           r_state;
    logic [WIDTH-1:0] r_pending;

    logic [WIDTH-1:0] w_remain;
    logic [AW-1:0]    w_cap_lsb;
    logic [AW-1:0]    w_rem_lsb;
    logic [AW:0]      w_cap_cnt;
    logic             w_rem_single;
    logic             w_transfer;

    function automatic logic [AW-1:0] f_lsb(input logic [WIDTH-1:0] v);
        logic [AW-1:0] idx;
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = AW'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [AW:0] f_popcount(input logic [WIDTH-1:0] v);
        logic [AW:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + {{AW{1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Vector left after the address currently on addr_out is consumed
    assign w_remain     = r_pending & ~(c_one << addr_out);
    assign w_rem_lsb    = f_lsb(w_remain);
    assign w_rem_single = (w_remain != '0) && ((w_remain & (w_remain - c_one)) == '0);
    assign w_cap_lsb    = f_lsb(match_vec);
    assign w_cap_cnt    = f_popcount(match_vec);
    assign w_transfer   = valid_out & ready_in & ena;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            valid_out <= 1'b0;
            addr_out  <= '0;
            last_out  <= 1'b0;
            hit_count <= '0;
            hit       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (ena) begin
            case (r_state)
                S_IDLE: begin
                    if (capture) begin
                        r_pending <= match_vec;
                        hit_count <= w_cap_cnt;
                        hit       <= |match_vec;
                        busy      <= 1'b1;
                        if (|match_vec) begin
                            r_state   <= S_EMIT;
                            valid_out <= 1'b1;
                            addr_out  <= w_cap_lsb;
                            last_out  <= (w_cap_cnt == c_cnt_one);
                        end else begin
                            r_state   <= S_FIN;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_transfer) begin
                        r_pending <= w_remain;
                        if (w_remain == '0) begin
                            // Final transfer raises done so FIN lasts one cycle
                            r_state   <= S_FIN;
                            valid_out <= 1'b0;
                            last_out  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            addr_out  <= w_rem_lsb;
                            last_out  <= w_rem_single;
                        end
                    end
                end
                S_FIN: begin
                    // An empty capture arrives here with done low and spends a cycle raising it
                    if (!done) begin
                        done    <= 1'b1;
                    end else begin
                        done    <= 1'b0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    valid_out <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_match_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_match_encoder
// Purpose  : Scoreboard bench for match_encoder with randomized handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_match_encoder;

    localparam int W = 16;
    localparam int A = 4;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         ena       = 1'b0;
    logic         capture   = 1'b0;
    logic [W-1:0] match_vec = '0;
    logic         ready_in  = 1'b0;
    logic         valid_out;
    logic [A-1:0] addr_out;
    logic         last_out;
    logic [A:0]   hit_count;
    logic         hit;
    logic         busy;
    logic         done;

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;

    logic [A:0]   exp_q[$];   // {last, addr}
    logic [A:0]   exp_hc  = '0;
    logic         exp_hit = 1'b0;

    logic         hold_prev = 1'b0;
    logic [A-1:0] hold_addr;
    logic         hold_last;
    logic [A:0]   mon_e;

    always #5 clk = ~clk;

    match_encoder #(.WIDTH(W), .AW(A)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .capture   (capture),
        .match_vec (match_vec),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .addr_out  (addr_out),
        .last_out  (last_out),
        .hit_count (hit_count),
        .hit       (hit),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: every set bit in ascending order; last when no set bits remain above it
    task automatic push_model(input logic [W-1:0] v);
        int remaining;
        remaining = $countones(v);
        exp_hc  = (A+1)'(remaining);
        exp_hit = (v != '0);
        for (int i = 0; i < W; i++) begin
            if (v[i]) begin
                remaining--;
                exp_q.push_back({remaining == 0, i[A-1:0]});
            end
        end
    endtask

    // Monitor: pops the scoreboard on each handshake, checks stability while stalled
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk("hold_valid", valid_out, 1);
                    chk("hold_addr", addr_out, hold_addr);
                    chk("hold_last", last_out, hold_last);
                end
                hold_prev = 1'b0;
                if (valid_out) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", valid_out, 0);
                    end else if (ready_in && ena) begin
                        mon_e = exp_q.pop_front();
                        chk("addr_out", addr_out, mon_e[A-1:0]);
                        chk("last_out", last_out, mon_e[A]);
                        chk("xfer_hit_count", hit_count, exp_hc);
                        chk("xfer_hit", hit, exp_hit);
                    end else begin
                        hold_prev = 1'b1;
                        hold_addr = addr_out;
                        hold_last = last_out;
                    end
                end
                if (done && ena) done_cnt++;
            end
        end
    end

    // mode: 0 full rate, 1 ready toggling, 2 random, 3 ena drop, 4 capture-while-stalled
    task automatic do_seq(input logic [W-1:0] v, input int mode);
        int bcnt;
        int it;
        int n;
        bcnt = 0;
        it   = 0;
        n    = $countones(v);
        push_model(v);
        done_cnt  = 0;
        capture   = 1'b1;
        match_vec = v;
        ena       = 1'b1;
        ready_in  = 1'b1;
        @(posedge clk); #1;
        capture   = 1'b0;
        match_vec = W'($urandom);
        while (busy && it < 400) begin
            bcnt++;
            case (mode)
                1: begin ready_in = (it % 2 == 0); ena = 1'b1; end
                2: begin
                    ready_in  = 1'($urandom % 2);
                    ena       = (($urandom % 4) != 0);
                    capture   = (($urandom % 3) == 0);
                    match_vec = W'($urandom);
                end
                3: begin ready_in = 1'b1; ena = (it >= 3); end
                4: begin
                    ready_in  = (it != 0);
                    capture   = (it == 0);
                    match_vec = 16'hF000;
                    ena       = 1'b1;
                end
                default: begin ready_in = 1'b1; ena = 1'b1; end
            endcase
            it++;
            @(posedge clk); #1;
        end
        capture = 1'b0;
        ena     = 1'b1;
        chk("seq_end_busy", busy, 0);
        if (mode == 0) chk("busy_cycles", bcnt, (n == 0) ? 2 : n + 1);
        chk("done_pulses", done_cnt, 1);
        chk("queue_left", exp_q.size(), 0);
        chk("hit_count", hit_count, exp_hc);
        chk("hit", hit, exp_hit);
        chk("idle_valid", valid_out, 0);
        exp_q.delete();
    endtask

    initial begin
        #1;
        chk("rst_valid", valid_out, 0);
        chk("rst_addr", addr_out, 0);
        chk("rst_last", last_out, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_hit", hit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ena = 1'b1;
        @(posedge clk); #1;

        do_seq(16'h8421, 0);
        do_seq(16'h0000, 0);
        do_seq(16'hFFFF, 1);
        do_seq(16'h0003, 4);
        do_seq(16'h0110, 3);

        // Asynchronous reset mid-sequence, after the first transfer
        push_model(16'h00F0);
        done_cnt  = 0;
        capture   = 1'b1;
        match_vec = 16'h00F0;
        ready_in  = 1'b1;
        ena       = 1'b1;
        @(posedge clk); #1;
        capture = 1'b0;
        @(posedge clk); #2;
        chk("pre_rst_addr", addr_out, 5);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", valid_out, 0);
        chk("arst_addr", addr_out, 0);
        chk("arst_last", last_out, 0);
        chk("arst_hit_count", hit_count, 0);
        chk("arst_hit", hit, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("arst_no_done", done_cnt, 0);
        do_seq(16'h0002, 0);

        for (int k = 0; k < 30; k++) begin
            logic [W-1:0] v;
            v = W'($urandom);
            if (k % 3 == 1) v = v & W'($urandom) & W'($urandom);
            if (k % 7 == 3) v = '0;
            do_seq(v, k % 3 == 0 ? 0 : (k % 3 == 1 ? 2 : 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/match_encoder.md
Name: match_encoder

Overview:
- Stage directly downstream of the associative-array match stage.
- Captures a match vector (bit i = entry i matched) on a strobe.
- Serialises every set bit, lowest index first, as a binary address over a valid/ready handshake.
- Reports total hit count, last-address marker and a completion pulse, so a controller or output mux can read all matching addresses one per transfer.

Parameters:
- WIDTH, 16, number of match-vector bits (entries in the array).
- AW, 4, address width; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design enable; when 0 the block holds all state
- capture  input  1  load match_vec and begin a search sequence
- match_vec  input  WIDTH  match vector from the match stage
- ready_in  input  1  consumer accepts addr_out this cycle
- valid_out  output  1  addr_out holds a valid matching address
- addr_out  output  AW  index of current matching entry
- last_out  output  1  addr_out is the final matching address of this sequence
- hit_count  output  AW+1  number of set bits in the captured vector
- hit  output  1  captured vector was non-zero
- busy  output  1  sequence in progress (state != IDLE)
- done  output  1  one-cycle pulse at sequence end

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; pending=0; valid_out=0; addr_out=0; last_out=0; hit_count=0; hit=0; busy=0; done=0. Reset mid-sequence aborts it immediately. No done pulse is issued for the aborted sequence.
- All outputs are registered.
- ena=0 freezes every register, including done. A done pulse present when ena falls persists until the next enabled cycle.
- transfer = valid_out & ready_in & ena.
- State IDLE:
  - On capture & ena: pending <= match_vec; hit_count <= popcount(match_vec); hit <= |match_vec.
  - If match_vec != 0: go to EMIT; valid_out <= 1; addr_out <= index of lowest set bit; last_out <= (popcount==1).
  - If match_vec == 0: go to FIN; valid_out stays 0.
  - Latency: first address visible the cycle after the capture edge.
- State EMIT:
  - valid_out=1; addr_out and last_out held stable until transfer.
  - On transfer: clear bit addr_out in pending.
    - If pending becomes 0: go to FIN; valid_out <= 0.
    - Else: addr_out <= lowest remaining set bit; last_out <= (exactly one bit remaining).
  - One address per cycle at full throughput (ready_in held 1).
- State FIN: done <= 1 for exactly one enabled cycle, then go to IDLE and done <= 0.
- hit_count and hit:
  - Hold their values until the next accepted capture.
  - Width AW+1 so that WIDTH matches (16) is representable.
- capture while busy (EMIT or FIN) is ignored. The captured vector is not altered.
- match_vec is sampled only on an accepted capture; changes afterwards have no effect.
- capture in the same cycle as FIN->IDLE is ignored; it is accepted only when the state is already IDLE.
- busy = (state != IDLE), registered alongside state.
- Sequence duration: N matches with ready_in=1 gives busy for N+1 cycles. A zero vector gives busy for 2 cycles (EMIT is skipped; FIN then back to IDLE).
- Lowest-set-bit search and popcount are combinational over WIDTH bits, feeding the registers. No multi-cycle scan.

Test Plan:
- Capture 0x8421, ready_in=1 -> addr_out 0,5,10,15 on four consecutive cycles with valid_out=1; last_out only with 15; hit_count=4, hit=1; done pulses one cycle after the final transfer; busy low next cycle.
- Capture 0x0000 -> valid_out never asserts; hit=0, hit_count=0; done pulses on the second cycle after capture; busy high exactly 2 cycles.
- Capture 0xFFFF, ready_in toggling 1,0,1,0 -> each addr_out (0..15) held stable while ready_in=0; 16 transfers total; hit_count=16 (5'b10000); last_out with 15.
- Capture 0x0003, then capture 0xF000 while EMIT with ready_in=0 -> second capture ignored; outputs 0 then 1 only; hit_count stays 2.
- Capture 0x0110, drop ena for 3 cycles while valid_out=1 and ready_in=1 -> no transfer, addr_out stays 4; resumes with 4 then 8 when ena returns.
- Capture 0x00F0, assert rst_n=0 asynchronously between clock edges after the first transfer -> all outputs 0 immediately, no done pulse; after release, a new capture of 0x0002 yields addr_out=1, last_out=1.
